// File: rtl/arb2_pkg.sv
// rtl/arb2_pkg.sv - shared types and constants for the two-requester mux arbiter
package arb2_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    G0   = 2'd1,
    G1   = 2'd2
  } state_t;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_0    = 2'b01;
  localparam logic [1:0] GNT_1    = 2'b10;

endpackage

// File: rtl/arb2_mux_ctrl_if.sv
// rtl/arb2_mux_ctrl_if.sv - two input streams, one output stream, grant status
interface arb2_mux_ctrl_if #(
  parameter int DW = 8
);
  logic          s0_valid;
  logic [DW-1:0] s0_data;
  logic          s0_last;
  logic          s0_ready;
  logic          s1_valid;
  logic [DW-1:0] s1_data;
  logic          s1_last;
  logic          s1_ready;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic          m_ready;
  logic [1:0]    grant;
  logic          busy;

  modport master (
    input  s0_valid, s0_data, s0_last, s1_valid, s1_data, s1_last, m_ready,
    output s0_ready, s1_ready, m_valid, m_data, m_last, grant, busy
  );

  modport slave (
    output s0_valid, s0_data, s0_last, s1_valid, s1_data, s1_last, m_ready,
    input  s0_ready, s1_ready, m_valid, m_data, m_last, grant, busy
  );
endinterface

// File: rtl/mux2_dw.sv
// rtl/mux2_dw.sv - DW-wide dataflow 2:1 mux
module mux2_dw #(
  parameter int DW = 8
) (
  input  logic          s,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [DW-1:0] y
);

  assign y = s ? b : a;

endmodule

// File: rtl/arb2_mux_ctrl.sv
// rtl/arb2_mux_ctrl.sv - packet-granular round-robin arbiter driving a registered 2:1 stream mux
module arb2_mux_ctrl
  import arb2_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  arb2_mux_ctrl_if.master bus
);

  state_t        state;
  logic          prio;
  logic          m_valid_q;
  logic [DW-1:0] m_data_q;
  logic          m_last_q;

  logic          sel;
  logic          ofree;
  logic          s0_rdy;
  logic          s1_rdy;
  logic          sel_valid;
  logic          sel_ready;
  logic          other_valid;
  logic          acc;
  logic [DW-1:0] sel_data;
  logic [0:0]    sel_last;

  assign sel   = (state == G1);
  assign ofree = !m_valid_q | bus.m_ready;

  // Ready depends combinationally on the output register so a stall blocks
  // the owner in the same cycle.
  assign s0_rdy = (state == G0) & ofree;
  assign s1_rdy = (state == G1) & ofree;
  assign bus.s0_ready = s0_rdy;
  assign bus.s1_ready = s1_rdy;

  mux2_dw #(.DW(DW)) u_data_mux (
    .s (sel),
    .a (bus.s0_data),
    .b (bus.s1_data),
    .y (sel_data)
  );

  mux2_dw #(.DW(1)) u_last_mux (
    .s (sel),
    .a (bus.s0_last),
    .b (bus.s1_last),
    .y (sel_last)
  );

  assign sel_valid   = sel ? bus.s1_valid : bus.s0_valid;
  assign sel_ready   = sel ? s1_rdy : s0_rdy;
  assign other_valid = sel ? bus.s0_valid : bus.s1_valid;
  assign acc         = sel_valid & sel_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      prio      <= 1'b0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_last_q  <= 1'b0;
    end else begin
      if (ofree) begin
        m_valid_q <= acc;
        m_data_q  <= sel_data;
        m_last_q  <= sel_last[0];
      end
      case (state)
        IDLE: begin
          if (bus.s0_valid && bus.s1_valid) state <= prio ? G1 : G0;
          else if (bus.s0_valid)            state <= G0;
          else if (bus.s1_valid)            state <= G1;
        end
        G0, G1: begin
          // Ownership only changes on the accepted last beat of a packet.
          if (acc && sel_last[0]) begin
            prio <= ~sel;
            if (other_valid)    state <= sel ? G0 : G1;
            else if (sel_valid) state <= state;
            else                state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    bus.grant = GNT_NONE;
    case (state)
      G0:      bus.grant = GNT_0;
      G1:      bus.grant = GNT_1;
      default: bus.grant = GNT_NONE;
    endcase
  end

  assign bus.busy    = (state != IDLE);
  assign bus.m_valid = m_valid_q;
  assign bus.m_data  = m_data_q;
  assign bus.m_last  = m_last_q;

endmodule

// File: tb/tb_arb2_mux_ctrl.sv
// tb/tb_arb2_mux_ctrl.sv - directed self-checking bench for arb2_mux_ctrl
module tb_arb2_mux_ctrl;
  import arb2_pkg::*;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  arb2_mux_ctrl_if #(.DW(8)) bus ();

  arb2_mux_ctrl #(.DW(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    bus.s0_valid = 1'b0; bus.s0_data = 8'h00; bus.s0_last = 1'b0;
    bus.s1_valid = 1'b0; bus.s1_data = 8'h00; bus.s1_last = 1'b0;
    bus.m_ready  = 1'b1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    clear_inputs();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    clear_inputs();
    tick();
    checks++; if (bus.m_valid !== 1'b0) begin errors++; $display("FAIL rst_m_valid got=%b exp=0", bus.m_valid); end
    checks++; if (bus.m_data !== 8'h00) begin errors++; $display("FAIL rst_m_data got=%h exp=00", bus.m_data); end
    checks++; if (bus.m_last !== 1'b0) begin errors++; $display("FAIL rst_m_last got=%b exp=0", bus.m_last); end
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++; if (bus.m_valid !== 1'b0) begin errors++; $display("FAIL idle_m_valid cyc=%0d got=%b exp=0", i, bus.m_valid); end
      checks++; if (bus.grant !== GNT_NONE) begin errors++; $display("FAIL idle_grant cyc=%0d got=%b exp=00", i, bus.grant); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL idle_busy cyc=%0d got=%b exp=0", i, bus.busy); end
      checks++; if ({bus.s0_ready, bus.s1_ready} !== 2'b00) begin errors++; $display("FAIL idle_ready cyc=%0d got=%b exp=00", i, {bus.s0_ready, bus.s1_ready}); end
    end
  endtask

  task automatic test_single_source;
    do_reset();
    bus.s0_valid = 1'b1; bus.s0_data = 8'hA1; bus.s0_last = 1'b0;
    tick();
    checks++; if (bus.grant !== GNT_0) begin errors++; $display("FAIL single_grant got=%b exp=01", bus.grant); end
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL single_busy got=%b exp=1", bus.busy); end
    checks++; if (bus.m_valid !== 1'b0) begin errors++; $display("FAIL single_bubble got=%b exp=0", bus.m_valid); end
    checks++; if (bus.s0_ready !== 1'b1) begin errors++; $display("FAIL single_ready got=%b exp=1", bus.s0_ready); end
    tick();
    checks++; if ({bus.m_valid, bus.m_data, bus.m_last} !== {1'b1, 8'hA1, 1'b0}) begin errors++; $display("FAIL single_a1 got=%b/%h/%b exp=1/a1/0", bus.m_valid, bus.m_data, bus.m_last); end
    bus.s0_data = 8'hA2;
    tick();
    checks++; if ({bus.m_valid, bus.m_data, bus.m_last} !== {1'b1, 8'hA2, 1'b0}) begin errors++; $display("FAIL single_a2 got=%b/%h/%b exp=1/a2/0", bus.m_valid, bus.m_data, bus.m_last); end
    bus.s0_data = 8'hA3; bus.s0_last = 1'b1;
    tick();
    checks++; if ({bus.m_valid, bus.m_data, bus.m_last} !== {1'b1, 8'hA3, 1'b1}) begin errors++; $display("FAIL single_a3 got=%b/%h/%b exp=1/a3/1", bus.m_valid, bus.m_data, bus.m_last); end
    clear_inputs();
    tick();
    checks++; if (bus.m_valid !== 1'b0) begin errors++; $display("FAIL single_end got=%b exp=0", bus.m_valid); end
  endtask

  task automatic test_both_idle;
    do_reset();
    bus.s0_valid = 1'b1; bus.s0_data = 8'h21; bus.s0_last = 1'b0;
    bus.s1_valid = 1'b1; bus.s1_data = 8'h91; bus.s1_last = 1'b1;
    tick();
    checks++; if (bus.grant !== GNT_0) begin errors++; $display("FAIL both_first_grant got=%b exp=01", bus.grant); end
    checks++; if (bus.s1_ready !== 1'b0) begin errors++; $display("FAIL both_s1_blocked got=%b exp=0", bus.s1_ready); end
    tick();
    checks++; if ({bus.m_valid, bus.m_data} !== {1'b1, 8'h21}) begin errors++; $display("FAIL both_x1 got=%b/%h exp=1/21", bus.m_valid, bus.m_data); end
    bus.s0_data = 8'h22; bus.s0_last = 1'b1;
    tick();
    checks++; if ({bus.m_valid, bus.m_data, bus.m_last} !== {1'b1, 8'h22, 1'b1}) begin errors++; $display("FAIL both_x2 got=%b/%h/%b exp=1/22/1", bus.m_valid, bus.m_data, bus.m_last); end
    checks++; if (bus.grant !== GNT_1) begin errors++; $display("FAIL both_switch_grant got=%b exp=10", bus.grant); end
    bus.s0_valid = 1'b0; bus.s0_last = 1'b0;
    tick();
    checks++; if ({bus.m_valid, bus.m_data, bus.m_last} !== {1'b1, 8'h91, 1'b1}) begin errors++; $display("FAIL both_no_bubble got=%b/%h/%b exp=1/91/1", bus.m_valid, bus.m_data, bus.m_last); end
    clear_inputs();
    tick();
  endtask

  task automatic test_alternate;
    int b0, b1, k, p, q, j;
    logic started, a0, a1;
    logic [7:0] exp_d;
    do_reset();
    b0 = 0; b1 = 0; k = 0; started = 1'b0;
    for (int c = 0; c < 40 && k < 16; c++) begin
      bus.s0_valid = 1'b1; bus.s0_data = 8'(8'h10 + b0); bus.s0_last = b0[0];
      bus.s1_valid = 1'b1; bus.s1_data = 8'(8'h80 + b1); bus.s1_last = b1[0];
      #1;
      a0 = bus.s0_valid & bus.s0_ready;
      a1 = bus.s1_valid & bus.s1_ready;
      if (a0 && !b0[0]) begin
        checks++; if (bus.grant !== GNT_0 || b1 != b0) begin errors++; $display("FAIL alt_s0_turn grant=%b b0=%0d b1=%0d exp=01 equal", bus.grant, b0, b1); end
      end
      if (a1 && !b1[0]) begin
        checks++; if (bus.grant !== GNT_1 || b0 != b1 + 2) begin errors++; $display("FAIL alt_s1_turn grant=%b b0=%0d b1=%0d exp=10 b0=b1+2", bus.grant, b0, b1); end
      end
      if (bus.m_valid === 1'b1) started = 1'b1;
      if (started) begin
        checks++; if (bus.m_valid !== 1'b1) begin errors++; $display("FAIL alt_gap beat=%0d got=%b exp=1", k, bus.m_valid); end
        p = k / 2; j = k % 2; q = p / 2;
        exp_d = (p % 2 == 1) ? 8'(8'h80 + 2 * q + j) : 8'(8'h10 + 2 * q + j);
        checks++; if (bus.m_data !== exp_d || bus.m_last !== (j == 1)) begin errors++; $display("FAIL alt_data beat=%0d got=%h/%b exp=%h/%b", k, bus.m_data, bus.m_last, exp_d, j == 1); end
        k++;
      end
      if (a0) b0++;
      if (a1) b1++;
      tick();
    end
    checks++; if (k != 16) begin errors++; $display("FAIL alt_count got=%0d exp=16", k); end
    clear_inputs();
  endtask

  task automatic test_backpressure;
    int b0, nout;
    logic [7:0] hold_d;
    logic stalled;
    do_reset();
    b0 = 0; nout = 0; stalled = 1'b0; hold_d = 8'h00;
    for (int c = 0; c < 20; c++) begin
      bus.m_ready  = !(c >= 3 && c <= 6);
      bus.s0_valid = (b0 < 4); bus.s0_data = 8'(8'hD0 + b0); bus.s0_last = (b0 == 3);
      #1;
      if (bus.m_valid && !bus.m_ready) begin
        checks++; if (bus.s0_ready !== 1'b0) begin errors++; $display("FAIL bp_ready cyc=%0d got=%b exp=0", c, bus.s0_ready); end
        if (!stalled) hold_d = bus.m_data;
        else begin
          checks++; if (bus.m_data !== hold_d) begin errors++; $display("FAIL bp_stable cyc=%0d got=%h exp=%h", c, bus.m_data, hold_d); end
        end
        stalled = 1'b1;
      end
      if (bus.m_valid && bus.m_ready) begin
        checks++; if (bus.m_data !== 8'(8'hD0 + nout) || bus.m_last !== (nout == 3)) begin errors++; $display("FAIL bp_beat idx=%0d got=%h/%b exp=%h/%b", nout, bus.m_data, bus.m_last, 8'(8'hD0 + nout), nout == 3); end
        nout++;
      end
      if (bus.s0_valid && bus.s0_ready) b0++;
      tick();
    end
    checks++; if (nout != 4 || !stalled) begin errors++; $display("FAIL bp_count got=%0d stalled=%b exp=4 stalled=1", nout, stalled); end
    clear_inputs();
  endtask

  task automatic test_hold_grant;
    int b0, b1, nout;
    logic s1done;
    logic [7:0] exp_d;
    do_reset();
    b0 = 0; b1 = 0; nout = 0; s1done = 1'b0;
    for (int c = 0; c < 25; c++) begin
      bus.s1_valid = (b1 < 3) && (b1 == 0 || c >= 5);
      bus.s1_data  = 8'(8'hE0 + b1); bus.s1_last = (b1 == 2);
      bus.s0_valid = (c >= 1); bus.s0_data = 8'(8'h50 + b0); bus.s0_last = 1'b0;
      #1;
      if (c >= 1 && !s1done) begin
        checks++; if (bus.grant !== GNT_1) begin errors++; $display("FAIL hold_grant cyc=%0d got=%b exp=10", c, bus.grant); end
      end
      if (bus.m_valid) begin
        exp_d = (nout < 3) ? 8'(8'hE0 + nout) : 8'(8'h50 + nout - 3);
        checks++; if (bus.m_data !== exp_d) begin errors++; $display("FAIL hold_data idx=%0d got=%h exp=%h", nout, bus.m_data, exp_d); end
        nout++;
      end
      if (bus.s1_valid && bus.s1_ready && bus.s1_last) s1done = 1'b1;
      if (bus.s0_valid && bus.s0_ready) b0++;
      if (bus.s1_valid && bus.s1_ready) b1++;
      tick();
    end
    checks++; if (!s1done || nout < 4) begin errors++; $display("FAIL hold_done s1done=%b nout=%0d exp=1 >=4", s1done, nout); end
    clear_inputs();
  endtask

  task automatic test_async_reset;
    do_reset();
    bus.s0_valid = 1'b1; bus.s0_data = 8'hA5; bus.s0_last = 1'b0;
    tick();
    tick();
    checks++; if (bus.m_valid !== 1'b1) begin errors++; $display("FAIL areset_pre got=%b exp=1", bus.m_valid); end
    #3;
    rst_n = 1'b0;
    #1;
    checks++; if ({bus.m_valid, bus.m_data, bus.m_last} !== 10'b0) begin errors++; $display("FAIL areset_out got=%b/%h/%b exp=0/00/0", bus.m_valid, bus.m_data, bus.m_last); end
    checks++; if ({bus.grant, bus.busy} !== 3'b000) begin errors++; $display("FAIL areset_state got=%b/%b exp=00/0", bus.grant, bus.busy); end
    checks++; if (bus.s0_ready !== 1'b0) begin errors++; $display("FAIL areset_ready got=%b exp=0", bus.s0_ready); end
    clear_inputs();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n  = 1'b0;
    clear_inputs();
    test_reset();
    test_single_source();
    test_both_idle();
    test_alternate();
    test_backpressure();
    test_hold_grant();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
